// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and helpers for the iterative AES-128 encryptor:
//   - SBOX      : forward S-box, byte b at bits [8*b +: 8] (MSB-first)
//   - RCON      : round constants, indexed 1..10
//   - sbox()    : S-box lookup
//   - xtime()   : multiply by x in GF(2^8)
//   - get_rcon(): round constant for a 4-bit round number, 0 outside 1..10
//   - rpc_legal(): legal ROUNDS_PER_CYCLE values (1, 2, 5, 10)
//   - aes_state_e : controller states
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round numbers outside 1..10 never reach a live round; returning zero
    // keeps them from aliasing onto a real constant.
    function automatic logic [7:0] get_rcon(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) begin
            return RCON[r];
        end
        return 8'h00;
    endfunction

    function automatic bit rpc_legal(input int r);
        return (r == 1) || (r == 2) || (r == 5) || (r == 10);
    endfunction

endpackage

// File: rtl/aes_round.sv
// ---------------------------------------------------------------------------
// aes_round
// One combinational AES-128 encryption round with on-the-fly key expansion.
//   state_in  [0:127] : state entering the round (byte 0 = bits 0:7)
//   key_in    [0:127] : round key used by the previous AddRoundKey
//   rcon      [7:0]   : round constant for this round
//   last              : final round, MixColumns is bypassed
//   state_out [0:127] : state after AddRoundKey with the next round key
//   key_out   [0:127] : next round key (fed to the following round)
// ---------------------------------------------------------------------------
module aes_round
    import aes_pkg::*;
(
    input  logic [0:127] state_in,
    input  logic [0:127] key_in,
    input  logic [7:0]   rcon,
    input  logic         last,
    output logic [0:127] state_out,
    output logic [0:127] key_out
);

    function automatic logic [0:127] sub_byte(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    // Byte index is 4*column + row; row r rotates left by r columns.
    function automatic logic [0:127] shift_row(input logic [0:127] s);
        logic [0:127] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c + r) +: 8] = s[8*(4*((c + r) % 4) + r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:127] mix_col(input logic [0:127] s);
        logic [0:127] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Words are taken MSB-first, so byte 0 of each word sits in [31:24].
    function automatic logic [0:127] key_gen(input logic [0:127] k,
                                             input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[0  +: 32];
        w1 = k[32 +: 32];
        w2 = k[64 +: 32];
        w3 = k[96 +: 32];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
             ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic [0:127] shifted;

    assign key_out   = key_gen(key_in, rcon);
    assign shifted   = shift_row(sub_byte(state_in));
    assign state_out = (last ? shifted : mix_col(shifted)) ^ key_out;

endmodule

// File: rtl/aes128_enc_iter.sv
// ---------------------------------------------------------------------------
// aes128_enc_iter
// Iterative AES-128 encryptor evaluating ROUNDS_PER_CYCLE rounds per clock
// with a valid/ready request port and a valid/ready result port.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : request handshake
//   in_data, in_key    : plaintext and cipher key (byte 0 = bits 0:7)
//   in_tag             : opaque tag, returned with the result
//   out_valid/out_ready: result handshake
//   out_data, out_tag  : ciphertext and tag, held stable while stalled
// Latency from acceptance edge to out_valid: 10/ROUNDS_PER_CYCLE cycles.
// ---------------------------------------------------------------------------
module aes128_enc_iter
    import aes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int TAG_W            = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:127]       in_data,
    input  logic [0:127]       in_key,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:127]       out_data,
    output logic [TAG_W-1:0]   out_tag
);

    if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_bad_rpc
        $error("aes128_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;
    localparam logic [3:0] RPC    = 4'(ROUNDS_PER_CYCLE);

    logic [1:0]       fsm_r;
    logic [0:127]     state_r;
    logic [0:127]     key_r;
    logic [3:0]       rnd_r;
    logic [TAG_W-1:0] tag_r;
    logic [0:127]     out_data_r;
    logic [TAG_W-1:0] out_tag_r;

    logic [0:127]     rnd_state;
    logic [0:127]     rnd_key;
    logic             rnd_ok;
    logic             last_step;
    logic             accept;

    // Round chain: copy i evaluates round rnd_r + i.
    for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
        logic [0:127] st_i, key_i, st_o, key_o;
        logic [3:0]   rnd_num;

        if (i == 0) begin : g_head
            assign st_i  = state_r;
            assign key_i = key_r;
        end else begin : g_link
            assign st_i  = g_rnd[i-1].st_o;
            assign key_i = g_rnd[i-1].key_o;
        end

        assign rnd_num = rnd_r + 4'(i);

        aes_round u_round (
            .state_in  (st_i),
            .key_in    (key_i),
            .rcon      (get_rcon(rnd_num)),
            .last      (rnd_num == 4'd10),
            .state_out (st_o),
            .key_out   (key_o)
        );
    end

    assign rnd_state = g_rnd[ROUNDS_PER_CYCLE-1].st_o;
    assign rnd_key   = g_rnd[ROUNDS_PER_CYCLE-1].key_o;

    // Only round numbers 1..10 are live; anything else is treated as corrupt.
    assign rnd_ok    = (rnd_r >= 4'd1) && (rnd_r <= 4'd10);
    assign last_step = ((rnd_r + RPC - 4'd1) == 4'd10);

    // Handshake outputs depend only on the state and out_ready.
    assign in_ready  = (fsm_r == S_IDLE) || ((fsm_r == S_DONE) && out_ready);
    assign out_valid = (fsm_r == S_DONE);
    assign accept    = in_valid && in_ready;

    assign out_data  = out_data_r;
    assign out_tag   = out_tag_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r      <= S_IDLE;
            state_r    <= '0;
            key_r      <= '0;
            rnd_r      <= '0;
            tag_r      <= '0;
            out_data_r <= '0;
            out_tag_r  <= '0;
        end else begin
            case (fsm_r)
                S_IDLE: ;
                S_BUSY: begin
                    state_r <= rnd_state;
                    key_r   <= rnd_key;
                    rnd_r   <= rnd_r + RPC;
                    if (!rnd_ok) begin
                        fsm_r <= S_IDLE;
                    end else if (last_step) begin
                        out_data_r <= rnd_state;
                        out_tag_r  <= tag_r;
                        fsm_r      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_r <= S_IDLE;
                    end
                end
                default: fsm_r <= S_IDLE;
            endcase

            // Acceptance happens only in IDLE or in DONE with out_ready, so it
            // never collides with the BUSY updates above.
            if (accept) begin
                state_r <= in_data ^ in_key;
                key_r   <= in_key;
                tag_r   <= in_tag;
                rnd_r   <= 4'd1;
                fsm_r   <= S_BUSY;
            end
        end
    end

endmodule

// File: tb/tb_aes128_enc_iter.sv
module tb_aes128_enc_iter;

    localparam int TAG_W = 4;

    localparam logic [0:127] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    typedef struct packed {
        logic [0:127]     data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    exp_t q1[$];
    exp_t q5[$];
    exp_t q10[$];

    logic             iv1 = 1'b0, or1 = 1'b0, ir1, ov1;
    logic [0:127]     id1 = '0, ik1 = '0, od1;
    logic [TAG_W-1:0] it1 = '0, ot1;
    logic             iv5 = 1'b0, or5 = 1'b0, ir5, ov5;
    logic [0:127]     id5 = '0, ik5 = '0, od5;
    logic [TAG_W-1:0] it5 = '0, ot5;
    logic             iv10 = 1'b0, or10 = 1'b0, ir10, ov10;
    logic [0:127]     id10 = '0, ik10 = '0, od10;
    logic [TAG_W-1:0] it10 = '0, ot10;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes128_enc_iter #(.ROUNDS_PER_CYCLE(1), .TAG_W(TAG_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .in_key(ik1), .in_tag(it1), .out_valid(ov1),
        .out_ready(or1), .out_data(od1), .out_tag(ot1));

    aes128_enc_iter #(.ROUNDS_PER_CYCLE(5), .TAG_W(TAG_W)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5),
        .in_data(id5), .in_key(ik5), .in_tag(it5), .out_valid(ov5),
        .out_ready(or5), .out_data(od5), .out_tag(ot5));

    aes128_enc_iter #(.ROUNDS_PER_CYCLE(10), .TAG_W(TAG_W)) dut10 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv10), .in_ready(ir10),
        .in_data(id10), .in_key(ik10), .in_tag(it10), .out_valid(ov10),
        .out_ready(or10), .out_data(od10), .out_tag(ot10));

    function automatic exp_t mk(input logic [0:127] d, input logic [TAG_W-1:0] t);
        exp_t e;
        e.data = d;
        e.tag  = t;
        return e;
    endfunction

    // Waits (from a falling edge) for out_valid of the R=1 instance.
    task automatic wait_ov1(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (ov1 === 1'b1) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        int at;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (ov1 !== 1'b0 || od1 !== '0 || ot1 !== '0) begin
            failures++;
            $display("FAIL reset_hold ov=%b data=%h tag=%h want 0/0/0", ov1, od1, ot1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ir1 !== 1'b1 || ir5 !== 1'b1 || ir10 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b%b%b want=111", ir1, ir5, ir10);
        end
        // Park a result in DONE, then reset asynchronously between edges.
        or1 = 1'b0; iv1 = 1'b1; id1 = P_B; ik1 = K_B; it1 = 4'ha;
        @(negedge clk);
        iv1 = 1'b0;
        wait_ov1(30, at);
        checks++;
        if (at < 0 || od1 !== C_B) begin
            failures++;
            $display("FAIL reset_pre_done at=%0d data=%h want=%h", at, od1, C_B);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov1 !== 1'b0 || od1 !== '0 || ot1 !== '0) begin
            failures++;
            $display("FAIL reset_async ov=%b data=%h tag=%h want 0/0/0", ov1, od1, ot1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (ir1 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_in_ready got=%b want=1", ir1);
        end
    endtask

    task automatic test_c1();
        int at, acc;
        exp_t e;
        @(negedge clk);
        or1 = 1'b1; iv1 = 1'b1; id1 = P_C1; ik1 = K_C1; it1 = 4'd5;
        #1;
        checks++;
        if (ir1 !== 1'b1) begin
            failures++;
            $display("FAIL c1_accept in_ready=%b want=1", ir1);
        end
        acc = cyc + 1;
        q1.push_back(mk(C_C1, 4'd5));
        @(negedge clk);
        iv1 = 1'b0;
        wait_ov1(30, at);
        checks++;
        if (at - acc != 10) begin
            failures++;
            $display("FAIL c1_latency got=%0d want=10", at - acc);
        end
        e = '0;
        if (q1.size() > 0) e = q1.pop_front();
        checks++;
        if (od1 !== e.data) begin
            failures++;
            $display("FAIL c1_data got=%h want=%h", od1, e.data);
        end
        checks++;
        if (ot1 !== e.tag) begin
            failures++;
            $display("FAIL c1_tag got=%0d want=%0d", ot1, e.tag);
        end
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0) begin
            failures++;
            $display("FAIL c1_single_transfer out_valid=%b want=0", ov1);
        end
    endtask

    task automatic test_appb();
        int acc;
        int lat5  = -1;
        int lat10 = -1;
        exp_t e;
        @(negedge clk);
        or5 = 1'b1; or10 = 1'b1;
        iv5  = 1'b1; id5  = P_B; ik5  = K_B; it5  = 4'd9;
        iv10 = 1'b1; id10 = P_B; ik10 = K_B; it10 = 4'd3;
        #1;
        checks++;
        if (ir5 !== 1'b1 || ir10 !== 1'b1) begin
            failures++;
            $display("FAIL appb_accept in_ready r5=%b r10=%b want 1/1", ir5, ir10);
        end
        acc = cyc + 1;
        q5.push_back(mk(C_B, 4'd9));
        q10.push_back(mk(C_B, 4'd3));
        @(negedge clk);
        iv5 = 1'b0; iv10 = 1'b0;
        for (int i = 0; i < 20 && (lat5 < 0 || lat10 < 0); i++) begin
            if (ov10 === 1'b1 && lat10 < 0) begin
                lat10 = cyc - acc;
                e = '0;
                if (q10.size() > 0) e = q10.pop_front();
                checks++;
                if (od10 !== e.data || ot10 !== e.tag) begin
                    failures++;
                    $display("FAIL appb_r10_result got=%h/%0d want=%h/%0d", od10, ot10, e.data, e.tag);
                end
            end
            if (ov5 === 1'b1 && lat5 < 0) begin
                lat5 = cyc - acc;
                e = '0;
                if (q5.size() > 0) e = q5.pop_front();
                checks++;
                if (od5 !== e.data || ot5 !== e.tag) begin
                    failures++;
                    $display("FAIL appb_r5_result got=%h/%0d want=%h/%0d", od5, ot5, e.data, e.tag);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (lat10 != 1) begin
            failures++;
            $display("FAIL appb_r10_latency got=%0d want=1", lat10);
        end
        checks++;
        if (lat5 != 2) begin
            failures++;
            $display("FAIL appb_r5_latency got=%0d want=2", lat5);
        end
    endtask

    task automatic test_backpressure();
        int at, acc;
        exp_t e;
        @(negedge clk);
        or1 = 1'b0; iv1 = 1'b1; id1 = P_C1; ik1 = K_C1; it1 = 4'd6;
        #1;
        acc = cyc + 1;
        q1.push_back(mk(C_C1, 4'd6));
        @(negedge clk);
        iv1 = 1'b0;
        wait_ov1(30, at);
        checks++;
        if (at - acc != 10) begin
            failures++;
            $display("FAIL bp_latency got=%0d want=10", at - acc);
        end
        e = '0;
        if (q1.size() > 0) e = q1[0];
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (od1 !== e.data || ot1 !== e.tag) begin
                failures++;
                $display("FAIL bp_stable cycle=%0d got=%h/%0d want=%h/%0d", k, od1, ot1, e.data, e.tag);
            end
            checks++;
            if (ir1 !== 1'b0 || ov1 !== 1'b1) begin
                failures++;
                $display("FAIL bp_handshake cycle=%0d in_ready=%b out_valid=%b want 0/1", k, ir1, ov1);
            end
            @(negedge clk);
        end
        or1 = 1'b1;
        #1;
        checks++;
        if (ir1 !== 1'b1 || ov1 !== 1'b1) begin
            failures++;
            $display("FAIL bp_release in_ready=%b out_valid=%b want 1/1", ir1, ov1);
        end
        if (q1.size() > 0) e = q1.pop_front();
        checks++;
        if (od1 !== e.data || ot1 !== e.tag) begin
            failures++;
            $display("FAIL bp_result got=%h/%0d want=%h/%0d", od1, ot1, e.data, e.tag);
        end
        @(negedge clk);
        checks++;
        if (ov1 !== 1'b0) begin
            failures++;
            $display("FAIL bp_single_transfer out_valid=%b want=0", ov1);
        end
    endtask

    task automatic test_back_to_back();
        int at, acc, acc2;
        exp_t e;
        @(negedge clk);
        or1 = 1'b1; iv1 = 1'b1; id1 = P_C1; ik1 = K_C1; it1 = 4'd1;
        #1;
        acc = cyc + 1;
        q1.push_back(mk(C_C1, 4'd1));
        @(negedge clk);
        iv1 = 1'b0;
        wait_ov1(30, at);
        checks++;
        if (at - acc != 10) begin
            failures++;
            $display("FAIL b2b_first_latency got=%0d want=10", at - acc);
        end
        // Second request offered in the DONE cycle itself.
        iv1 = 1'b1; id1 = P_B; ik1 = K_B; it1 = 4'd2;
        #1;
        checks++;
        if (ir1 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_same_cycle_accept in_ready=%b want=1", ir1);
        end
        acc2 = cyc + 1;
        e = '0;
        if (q1.size() > 0) e = q1.pop_front();
        checks++;
        if (od1 !== e.data || ot1 !== e.tag) begin
            failures++;
            $display("FAIL b2b_first_result got=%h/%0d want=%h/%0d", od1, ot1, e.data, e.tag);
        end
        q1.push_back(mk(C_B, 4'd2));
        @(negedge clk);
        iv1 = 1'b0;
        checks++;
        if (ov1 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_busy_after_accept out_valid=%b want=0", ov1);
        end
        wait_ov1(30, at);
        checks++;
        if (at - acc2 != 10) begin
            failures++;
            $display("FAIL b2b_second_latency got=%0d want=10", at - acc2);
        end
        e = '0;
        if (q1.size() > 0) e = q1.pop_front();
        checks++;
        if (od1 !== e.data || ot1 !== e.tag) begin
            failures++;
            $display("FAIL b2b_second_result got=%h/%0d want=%h/%0d", od1, ot1, e.data, e.tag);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int at, acc, hits;
        exp_t e;
        @(negedge clk);
        or1 = 1'b1; iv1 = 1'b1; id1 = P_C1; ik1 = K_C1; it1 = 4'd7;
        #1;
        acc = cyc + 1;
        @(negedge clk);
        iv1 = 1'b0;
        @(negedge clk);
        iv1 = 1'b1; id1 = P_B; ik1 = K_B; it1 = 4'd8;
        #1;
        checks++;
        if (ir1 !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy_in_ready got=%b want=0", ir1);
        end
        @(negedge clk);
        iv1 = 1'b0;
        @(negedge clk);
        // Round 4 is being evaluated here.
        checks++;
        if (cyc - acc != 3 || ov1 !== 1'b0) begin
            failures++;
            $display("FAIL abort_position cycle=%0d out_valid=%b want 3/0", cyc - acc, ov1);
        end
        #2 rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ov1 === 1'b1) hits++;
        end
        checks++;
        if (hits != 0) begin
            failures++;
            $display("FAIL abort_no_output out_valid_cycles=%0d want=0", hits);
        end
        iv1 = 1'b1; id1 = P_C1; ik1 = K_C1; it1 = 4'd4;
        #1;
        acc = cyc + 1;
        q1.push_back(mk(C_C1, 4'd4));
        @(negedge clk);
        iv1 = 1'b0;
        wait_ov1(30, at);
        checks++;
        if (at - acc != 10) begin
            failures++;
            $display("FAIL abort_recover_latency got=%0d want=10", at - acc);
        end
        e = '0;
        if (q1.size() > 0) e = q1.pop_front();
        checks++;
        if (od1 !== e.data || ot1 !== e.tag) begin
            failures++;
            $display("FAIL abort_recover_result got=%h/%0d want=%h/%0d", od1, ot1, e.data, e.tag);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_c1();
        test_appb();
        test_backpressure();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
